// File: rtl/axi_stream_header_mux_if.sv
// Signal bundle for axi_stream_header_mux: input stream, output stream,
// per-packet command channel and the empty-packet drop indication.
// "slave" is the view of the mux itself; "master" is the view of whatever
// drives it (a neighbouring block or a testbench).
interface axi_stream_header_mux_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) ();
  // Input stream
  logic                    s_valid;
  logic [DATA_WD-1:0]      s_data;
  logic [DATA_BYTE_WD-1:0] s_keep;
  logic                    s_last;
  logic                    s_ready;
  // Output stream
  logic                    m_valid;
  logic [DATA_WD-1:0]      m_data;
  logic [DATA_BYTE_WD-1:0] m_keep;
  logic                    m_last;
  logic                    m_ready;
  // Command channel
  logic                    cmd_valid;
  logic                    cmd_strip;
  logic [BYTE_CNT_WD-1:0]  cmd_cnt;
  logic [DATA_WD-1:0]      cmd_data;
  logic                    cmd_ready;
  // Status
  logic                    drop_pulse;

  modport slave (
    input  s_valid, s_data, s_keep, s_last, m_ready,
           cmd_valid, cmd_strip, cmd_cnt, cmd_data,
    output s_ready, m_valid, m_data, m_keep, m_last, cmd_ready, drop_pulse
  );

  modport master (
    output s_valid, s_data, s_keep, s_last, m_ready,
           cmd_valid, cmd_strip, cmd_cnt, cmd_data,
    input  s_ready, m_valid, m_data, m_keep, m_last, cmd_ready, drop_pulse
  );
endinterface

// File: rtl/axi_stream_header_mux.sv
// Per-packet header insert / header strip on a byte-packed AXI-Stream.
// A command selects insert (prepend N header bytes) or strip (drop the first
// N packet bytes). Bytes are merged through a carry register holding up to
// one beat of MSB-aligned bytes; every emitted beat is registered.
module axi_stream_header_mux #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
  input logic                     clk,
  input logic                     rst,
  axi_stream_header_mux_if.slave  bus
);

  // Totals reach 2*W, so they need one more bit than a per-beat count.
  localparam int TW = BYTE_CNT_WD + 1;
  localparam logic [BYTE_CNT_WD-1:0] W_CNT = BYTE_CNT_WD'(DATA_BYTE_WD);
  localparam logic [TW-1:0]          W_T   = TW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  // MSB-aligned keep with cnt leading ones.
  function automatic logic [DATA_BYTE_WD-1:0] cnt_to_keep(input logic [TW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) k[DATA_BYTE_WD-1-i] = (TW'(i) < cnt);
    return k;
  endfunction

  // Expand byte enables into a bit mask over the data word.
  function automatic logic [DATA_WD-1:0] keep_to_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{keep[i]}};
    return m;
  endfunction

  function automatic logic [TW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] keep);
    logic [TW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + {{(TW-1){1'b0}}, keep[i]};
    return c;
  endfunction

  state_t                  r_state;
  logic [DATA_WD-1:0]      r_carry;
  logic [BYTE_CNT_WD-1:0]  r_carry_cnt;
  logic [BYTE_CNT_WD-1:0]  r_skip;
  logic                    r_m_valid;
  logic [DATA_WD-1:0]      r_m_data;
  logic [DATA_BYTE_WD-1:0] r_m_keep;
  logic                    r_m_last;
  logic                    r_drop;

  state_t                  w_nxt_state;
  logic [DATA_WD-1:0]      w_nxt_carry;
  logic [BYTE_CNT_WD-1:0]  w_nxt_carry_cnt;
  logic [BYTE_CNT_WD-1:0]  w_nxt_skip;
  logic                    w_nxt_m_valid;
  logic [DATA_WD-1:0]      w_nxt_m_data;
  logic [DATA_BYTE_WD-1:0] w_nxt_m_keep;
  logic                    w_nxt_m_last;
  logic                    w_nxt_drop;
  logic                    w_s_ready;
  logic                    w_cmd_ready;

  logic                    w_slot_free;
  logic [TW-1:0]           w_k;
  logic [TW-1:0]           w_skip_ext;
  logic [TW-1:0]           w_k_eff;
  logic [DATA_WD-1:0]      w_in_al;
  logic [2*DATA_WD-1:0]    w_cat;
  logic [TW-1:0]           w_total;

  // Byte-merge datapath: the incoming beat, minus skipped bytes, is packed
  // directly behind the carry bytes. Unused byte lanes stay zero because the
  // carry and the masked input are both zero-filled beyond their counts.
  assign w_slot_free = !r_m_valid || bus.m_ready;
  assign w_k         = popcount(bus.s_keep);
  assign w_skip_ext  = {1'b0, r_skip};
  assign w_k_eff     = (w_k >= w_skip_ext) ? (w_k - w_skip_ext) : '0;
  assign w_in_al     = (bus.s_data & keep_to_mask(bus.s_keep)) << {r_skip, 3'b000};
  assign w_cat       = {r_carry, {DATA_WD{1'b0}}}
                     | ({w_in_al, {DATA_WD{1'b0}}} >> {r_carry_cnt, 3'b000});
  assign w_total     = {1'b0, r_carry_cnt} + w_k_eff;

  // Next-state, handshake and output-beat selection.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and no latch is inferred.
    w_nxt_state     = r_state;
    w_nxt_carry     = r_carry;
    w_nxt_carry_cnt = r_carry_cnt;
    w_nxt_skip      = r_skip;
    w_nxt_m_valid   = r_m_valid && !bus.m_ready;
    w_nxt_m_data    = r_m_data;
    w_nxt_m_keep    = r_m_keep;
    w_nxt_m_last    = r_m_last;
    w_nxt_drop      = 1'b0;
    w_s_ready       = 1'b0;
    w_cmd_ready     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_nxt_state = ST_RUN;
          if (bus.cmd_strip) begin
            w_nxt_carry     = '0;
            w_nxt_carry_cnt = '0;
            w_nxt_skip      = bus.cmd_cnt;
          end else begin
            w_nxt_carry     = bus.cmd_data & keep_to_mask(cnt_to_keep({1'b0, bus.cmd_cnt}));
            w_nxt_carry_cnt = bus.cmd_cnt;
            w_nxt_skip      = '0;
          end
        end
      end

      ST_RUN: begin
        if (r_carry_cnt == W_CNT) begin
          // A full carry (header of N=W) goes out on its own before any input.
          if (w_slot_free) begin
            w_nxt_m_valid   = 1'b1;
            w_nxt_m_data    = r_carry;
            w_nxt_m_keep    = '1;
            w_nxt_m_last    = 1'b0;
            w_nxt_carry     = '0;
            w_nxt_carry_cnt = '0;
          end
        end else begin
          w_s_ready = w_slot_free;
          if (bus.s_valid && w_slot_free) begin
            w_nxt_skip = '0;
            if (!bus.s_last) begin
              if (w_total >= W_T) begin
                w_nxt_m_valid   = 1'b1;
                w_nxt_m_data    = w_cat[2*DATA_WD-1:DATA_WD];
                w_nxt_m_keep    = '1;
                w_nxt_m_last    = 1'b0;
                w_nxt_carry     = w_cat[DATA_WD-1:0];
                w_nxt_carry_cnt = BYTE_CNT_WD'(w_total - W_T);
              end else begin
                w_nxt_carry     = w_cat[2*DATA_WD-1:DATA_WD];
                w_nxt_carry_cnt = BYTE_CNT_WD'(w_total);
              end
            end else if (w_total == '0) begin
              // Everything was stripped: report it instead of emitting a beat.
              w_nxt_drop      = 1'b1;
              w_nxt_state     = ST_IDLE;
              w_nxt_carry     = '0;
              w_nxt_carry_cnt = '0;
            end else if (w_total <= W_T) begin
              w_nxt_m_valid   = 1'b1;
              w_nxt_m_data    = w_cat[2*DATA_WD-1:DATA_WD];
              w_nxt_m_keep    = cnt_to_keep(w_total);
              w_nxt_m_last    = 1'b1;
              w_nxt_state     = ST_IDLE;
              w_nxt_carry     = '0;
              w_nxt_carry_cnt = '0;
            end else begin
              w_nxt_m_valid   = 1'b1;
              w_nxt_m_data    = w_cat[2*DATA_WD-1:DATA_WD];
              w_nxt_m_keep    = '1;
              w_nxt_m_last    = 1'b0;
              w_nxt_carry     = w_cat[DATA_WD-1:0];
              w_nxt_carry_cnt = BYTE_CNT_WD'(w_total - W_T);
              w_nxt_state     = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (w_slot_free) begin
          w_nxt_m_valid   = 1'b1;
          w_nxt_m_data    = r_carry;
          w_nxt_m_keep    = cnt_to_keep({1'b0, r_carry_cnt});
          w_nxt_m_last    = 1'b1;
          w_nxt_carry     = '0;
          w_nxt_carry_cnt = '0;
          w_nxt_state     = ST_IDLE;
        end
      end

      default: w_nxt_state = ST_IDLE;
    endcase

    // Both readies stay low while reset is held.
    if (rst) begin
      w_s_ready   = 1'b0;
      w_cmd_ready = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= ST_IDLE;
      // NOTE: the carry bytes are cleared too, not just the count, so a
      // reset mid-packet can never leak stale bytes into a later beat.
      r_carry     <= '0;
      r_carry_cnt <= '0;
      r_skip      <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_keep    <= '0;
      r_m_last    <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_carry     <= w_nxt_carry;
      r_carry_cnt <= w_nxt_carry_cnt;
      r_skip      <= w_nxt_skip;
      r_m_valid   <= w_nxt_m_valid;
      r_m_data    <= w_nxt_m_data;
      r_m_keep    <= w_nxt_m_keep;
      r_m_last    <= w_nxt_m_last;
      r_drop      <= w_nxt_drop;
    end
  end

  assign bus.m_valid    = r_m_valid;
  assign bus.m_data     = r_m_data;
  assign bus.m_keep     = r_m_keep;
  assign bus.m_last     = r_m_last;
  assign bus.drop_pulse = r_drop;
  assign bus.s_ready    = w_s_ready;
  assign bus.cmd_ready  = w_cmd_ready;

endmodule

// File: tb/tb_axi_stream_header_mux.sv
// Scoreboard bench for axi_stream_header_mux (W=4). A byte-level model turns
// each command + packet into the expected output byte stream, chops it into
// beats and queues them; an independent monitor pops and compares every
// output transfer and checks that stalled outputs hold steady.
module tb_axi_stream_header_mux;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [W-1:0]  keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_stream_header_mux_if #(.DATA_WD(DW), .DATA_BYTE_WD(W), .BYTE_CNT_WD(CW)) bus ();

  axi_stream_header_mux #(.DATA_WD(DW), .DATA_BYTE_WD(W), .BYTE_CNT_WD(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t exp_q[$];
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    exp_drops = 0;
  int    obs_drops = 0;
  int    mr_mode   = 0;   // 0: m_ready high, 1: random, 2: low
  bit    rand_gaps = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: expected output bytes = header ++ packet (insert) or
  // packet without its first n bytes (strip), then cut into W-byte beats.
  task automatic model_packet(input bit strip, input int n, input logic [DW-1:0] hdr,
                              input byte unsigned pkt[$]);
    byte unsigned outb[$];
    beat_t b;
    if (!strip) begin
      for (int i = 0; i < n; i++) outb.push_back(hdr[DW-1-8*i -: 8]);
      foreach (pkt[i]) outb.push_back(pkt[i]);
    end else begin
      for (int i = n; i < pkt.size(); i++) outb.push_back(pkt[i]);
    end
    if (outb.size() == 0) exp_drops++;
    for (int base = 0; base < outb.size(); base += W) begin
      b = '0;
      for (int j = 0; j < W; j++) begin
        if (base + j < outb.size()) begin
          b.data[DW-1-8*j -: 8] = outb[base+j];
          b.keep[W-1-j]         = 1'b1;
        end
      end
      b.last = (base + W >= outb.size());
      exp_q.push_back(b);
    end
  endtask

  task automatic gap();
    if (rand_gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // All drive tasks start and end at posedge+1.
  task automatic send_cmd(input bit strip, input int n, input logic [DW-1:0] hdr);
    bit hs = 1'b0;
    int t  = 0;
    gap();
    bus.cmd_valid = 1'b1;
    bus.cmd_strip = strip;
    bus.cmd_cnt   = CW'(n);
    bus.cmd_data  = hdr;
    while (!hs && t < 1000) begin
      @(negedge clk);
      hs = bus.cmd_ready;
      @(posedge clk);
      t++;
    end
    if (!hs) fail_now("cmd_handshake_timeout");
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = DW'($urandom);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input bit last);
    bit hs = 1'b0;
    int t  = 0;
    gap();
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = last;
    while (!hs && t < 1000) begin
      @(negedge clk);
      hs = bus.s_ready;
      @(posedge clk);
      t++;
    end
    if (!hs) fail_now("beat_handshake_timeout");
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = DW'($urandom);
  endtask

  task automatic send_packet(input byte unsigned pkt[$]);
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    for (int base = 0; base < pkt.size(); base += W) begin
      d = DW'($urandom);   // unused lanes carry garbage on purpose
      k = '0;
      for (int j = 0; j < W; j++) begin
        if (base + j < pkt.size()) begin
          d[DW-1-8*j -: 8] = pkt[base+j];
          k[W-1-j]         = 1'b1;
        end
      end
      send_beat(d, k, base + W >= pkt.size());
    end
  endtask

  task automatic run_packet(input bit strip, input int n, input logic [DW-1:0] hdr,
                            input byte unsigned pkt[$]);
    model_packet(strip, n, hdr, pkt);
    send_cmd(strip, n, hdr);
    send_packet(pkt);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output-ready driver.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ($urandom_range(0, 3) != 0);
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare each transfer against the scoreboard, check stall hold.
  logic [DW+W+1:0] held;
  bit              held_v = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("stall_hold", {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last}, held);
      if (bus.drop_pulse) obs_drops++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output_beat");
        else begin
          e = exp_q.pop_front();
          check("beat", {bus.m_data, bus.m_keep, bus.m_last}, e);
        end
      end
      held_v = bus.m_valid && !bus.m_ready;
      held   = {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned pkt[$];
    int len;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_keep    = '0;
    bus.s_last    = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_strip = 1'b0;
    bus.cmd_cnt   = '0;
    bus.cmd_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", bus.m_valid, 0);
    check("reset_m_bus", {bus.m_data, bus.m_keep, bus.m_last}, 0);
    check("reset_readies", {bus.s_ready, bus.cmd_ready, bus.drop_pulse}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    // Insert N=2 across three beats, no flush
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    run_packet(1'b0, 2, 32'hAABB_0000, pkt);

    // Insert N=3 on a single beat -> FLUSH, input held off
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_packet(1'b0, 3, 32'hAABB_CC00, pkt);
    @(negedge clk);
    check("s_ready_low_in_flush", bus.s_ready, 0);
    @(posedge clk);
    #1;

    // Strip N=4 drops the whole first beat
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_packet(1'b1, 4, 32'h0, pkt);

    // Strip N=1 on one beat
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_packet(1'b1, 1, 32'h0, pkt);

    // Strip N=3 on a 2-byte packet -> nothing left, drop pulse
    pkt = '{8'h11, 8'h22};
    run_packet(1'b1, 3, 32'h0, pkt);
    @(negedge clk);
    check("drop_pulse_high", bus.drop_pulse, 1);
    check("drop_no_output", bus.m_valid, 0);
    check("drop_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    check("drop_pulse_one_cycle", bus.drop_pulse, 0);
    @(posedge clk);
    #1;

    // Random packets, modes and counts under random backpressure and gaps
    mr_mode   = 1;
    rand_gaps = 1'b1;
    for (int p = 0; p < 100; p++) begin
      pkt.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      if (p % 3 == 2)
        run_packet(1'b1, $urandom_range(0, W), DW'($urandom), pkt);
      else
        run_packet(1'b0, (p % 3 == 0) ? W : 0, DW'($urandom), pkt);
    end
    wait_drain();

    // Reset mid-packet with a pending output beat and 3 carry bytes
    rand_gaps = 1'b0;
    mr_mode   = 2;
    @(posedge clk);
    #1;
    send_cmd(1'b0, 3, 32'hAABB_CC00);
    send_beat(32'h1122_3344, 4'b1111, 1'b0);
    @(negedge clk);
    check("pre_reset_m_valid", bus.m_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_m_valid", bus.m_valid, 0);
    check("midreset_m_bus", {bus.m_data, bus.m_keep, bus.m_last}, 0);
    check("midreset_readies", {bus.s_ready, bus.cmd_ready, bus.drop_pulse}, 0);
    exp_q.delete();
    mr_mode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Packets after reset must not see stale carry bytes
    pkt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    run_packet(1'b0, 0, 32'hFFFF_FFFF, pkt);
    pkt = '{8'h01, 8'h02, 8'h03};
    run_packet(1'b0, W, 32'hC0DE_CAFE, pkt);
    wait_drain();

    check("drop_count", obs_drops, exp_drops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
